// File: rtl/sudoku_ctrl_pkg.sv
// Shared constants, status codes and FSM encodings for the sudoku propagation controller.
// Also holds the cell-peer helper used by the propagation stage.
package sudoku_ctrl_pkg;

    localparam int NCELL           = 81;
    localparam int NDIG            = 9;
    localparam int NBITS           = 729;
    localparam int CELL_SINGLE_POP = 8;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,
        ST_SOLVED   = 3'd1,
        ST_CONFLICT = 3'd2,
        ST_STUCK    = 3'd3,
        ST_TIMEOUT  = 3'd4,
        ST_ABORTED  = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Cells a and b are peers when distinct and sharing a row, column or 3x3 box.
    function automatic logic is_peer(input int a, input int b);
        logic same_row;
        logic same_col;
        logic same_box;
        same_row = ((a / 9) == (b / 9));
        same_col = ((a % 9) == (b % 9));
        same_box = ((a / 27) == (b / 27)) && (((a % 9) / 3) == ((b % 9) / 3));
        return (a != b) && (same_row || same_col || same_box);
    endfunction

endpackage

// File: rtl/sudoku_mask_stg2.sv
// One combinational naked-single elimination pass: every settled cell removes its
// digit from all of its row, column and box peers.
module sudoku_mask_stg2
    import sudoku_ctrl_pkg::*;
(
    input  logic [NBITS-1:0] mask_i,
    output logic [NBITS-1:0] mask_o
);

    logic [NCELL-1:0][NDIG-1:0] single_s;

    // One-hot digit of each settled cell; zero when the cell still has choices.
    for (genvar c = 0; c < NCELL; c++) begin : g_single
        assign single_s[c] = ($countones(mask_i[c*NDIG +: NDIG]) == CELL_SINGLE_POP)
                           ? ~mask_i[c*NDIG +: NDIG] : {NDIG{1'b0}};
    end

    for (genvar c = 0; c < NCELL; c++) begin : g_elim
        logic [NDIG-1:0] elim_s;

        // Gather the settled digits of every peer of this cell.
        always_comb begin
            elim_s = {NDIG{1'b0}};
            for (int p = 0; p < NCELL; p++) begin
                if (is_peer(c, p)) begin
                    elim_s = elim_s | single_s[p];
                end else begin
                    elim_s = elim_s;
                end
            end
        end

        assign mask_o[c*NDIG +: NDIG] = mask_i[c*NDIG +: NDIG] | elim_s;
    end

endmodule

// File: rtl/sudoku_prop_ctrl.sv
// Job controller that iterates the propagation pass over a 729-bit candidate mask
// until the grid is solved, conflicting, stuck, timed out or aborted.
module sudoku_prop_ctrl
    import sudoku_ctrl_pkg::*;
#(
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NBITS-1:0]  mask_in,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [NBITS-1:0]  mask_out
);

    state_e             state_q,  state_d;
    status_e            status_q, status_d;
    logic [NBITS-1:0]   mask_q,   mask_d;
    logic [ITER_W-1:0]  iter_q,   iter_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [NBITS-1:0]   prop_s;
    logic [NCELL-1:0]   cell_full_s;
    logic [NCELL-1:0]   cell_single_s;
    logic               conflict_s;
    logic               solved_s;
    logic               stuck_s;
    logic               timeout_s;

    sudoku_mask_stg2 u_stg2 (
        .mask_i (mask_q),
        .mask_o (prop_s)
    );

    for (genvar c = 0; c < NCELL; c++) begin : g_cell
        assign cell_full_s[c]   = &mask_q[c*NDIG +: NDIG];
        assign cell_single_s[c] = ($countones(mask_q[c*NDIG +: NDIG]) == CELL_SINGLE_POP);
    end

    assign conflict_s = |cell_full_s;
    assign solved_s   = &cell_single_s;
    assign stuck_s    = (prop_s == mask_q);
    assign timeout_s  = (iter_q == ITER_W'(MAX_ITER));

    // Next-state and next-output computation; terminal checks are priority ordered.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        mask_d   = mask_q;
        iter_d   = iter_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d   = mask_in;
                    iter_d   = {ITER_W{1'b0}};
                    status_d = ST_NONE;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    status_d = ST_ABORTED;
                end else if (conflict_s) begin
                    status_d = ST_CONFLICT;
                end else if (solved_s) begin
                    status_d = ST_SOLVED;
                end else if (stuck_s) begin
                    status_d = ST_STUCK;
                end else if (timeout_s) begin
                    status_d = ST_TIMEOUT;
                end else begin
                    status_d = status_q;
                end
                if (abort || conflict_s || solved_s || stuck_s || timeout_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    mask_d  = prop_s;
                    iter_d  = iter_q + ITER_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            status_q <= ST_NONE;
            mask_q   <= {NBITS{1'b0}};
            iter_q   <= {ITER_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            iter_q   <= iter_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign status   = status_q;
    assign iter_cnt = iter_q;
    assign mask_out = mask_q;

endmodule

// File: tb/tb_sudoku_prop_ctrl.sv
// Self-checking bench: two controllers (MAX_ITER 64 and 1) compared every cycle against
// a grid-level reference model, plus directed jobs with hand-computed expectations.
module tb_sudoku_prop_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [728:0] mask_in = '0;

    logic         busy0, done0, busy1, done1;
    logic [2:0]   status0, status1;
    logic [7:0]   iter0, iter1;
    logic [728:0] mout0, mout1;

    int n_checks = 0;
    int n_fail   = 0;

    sudoku_prop_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask_in(mask_in),
        .busy(busy0), .done(done0), .status(status0), .iter_cnt(iter0), .mask_out(mout0)
    );

    sudoku_prop_ctrl #(.MAX_ITER(1), .ITER_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask_in(mask_in),
        .busy(busy1), .done(done1), .status(status1), .iter_cnt(iter1), .mask_out(mout1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chkm(input string nm, input logic [728:0] act, input logic [728:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (grid level) ----------------
    function automatic logic [728:0] prop(input logic [728:0] m);
        int val[81];
        int crow[9][9];
        int ccol[9][9];
        int cbox[9][9];
        int zeros, zd, n, x, y, b;
        logic [728:0] r;
        for (int i = 0; i < 9; i++)
            for (int d = 0; d < 9; d++) begin
                crow[i][d] = 0; ccol[i][d] = 0; cbox[i][d] = 0;
            end
        for (int c = 0; c < 81; c++) begin
            zeros = 0; zd = 0;
            for (int d = 0; d < 9; d++)
                if (!m[c*9+d]) begin zeros++; zd = d; end
            val[c] = (zeros == 1) ? zd : -1;
            x = c / 9; y = c % 9; b = (x / 3) * 3 + y / 3;
            if (zeros == 1) begin
                crow[x][zd]++; ccol[y][zd]++; cbox[b][zd]++;
            end
        end
        r = m;
        for (int c = 0; c < 81; c++) begin
            x = c / 9; y = c % 9; b = (x / 3) * 3 + y / 3;
            for (int d = 0; d < 9; d++) begin
                n = crow[x][d] + ccol[y][d] + cbox[b][d] - ((val[c] == d) ? 3 : 0);
                if (n > 0) r[c*9+d] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic bit has_full(input logic [728:0] m);
        for (int c = 0; c < 81; c++)
            if (m[c*9 +: 9] == 9'h1FF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit all_single(input logic [728:0] m);
        int z;
        for (int c = 0; c < 81; c++) begin
            z = 0;
            for (int d = 0; d < 9; d++) if (!m[c*9+d]) z++;
            if (z != 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    int           m_phase[2];   // 0 idle, 1 running, 2 reporting
    int           m_status[2];
    int           m_iter[2];
    logic [728:0] m_mask[2];
    int           max_it[2] = '{64, 1};

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_status[k] = 0; m_iter[k] = 0; m_mask[k] = '0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        logic [728:0] nx;
        int st;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_phase[k] = 0; m_status[k] = 0; m_iter[k] = 0; m_mask[k] = '0;
            end else if (m_phase[k] == 2) begin
                m_phase[k] = 0;
            end else if (m_phase[k] == 0) begin
                if (start) begin
                    m_mask[k] = mask_in; m_iter[k] = 0; m_status[k] = 0; m_phase[k] = 1;
                end
            end else begin
                nx = m_mask[k];
                if (abort) st = 5;
                else if (has_full(m_mask[k])) st = 2;
                else if (all_single(m_mask[k])) st = 1;
                else begin
                    nx = prop(m_mask[k]);
                    if (nx == m_mask[k]) st = 3;
                    else if (m_iter[k] == max_it[k]) st = 4;
                    else st = 0;
                end
                if (st != 0) begin
                    m_status[k] = st; m_phase[k] = 2;
                end else begin
                    m_mask[k] = nx; m_iter[k] = m_iter[k] + 1;
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic b, input logic d, input logic [2:0] s,
                            input logic [7:0] it, input logic [728:0] mo);
        chk($sformatf("busy%0d", k), int'(b), int'(m_phase[k] != 0));
        chk($sformatf("done%0d", k), int'(d), int'(m_phase[k] == 2));
        chk($sformatf("status%0d", k), int'(s), m_status[k]);
        chk($sformatf("iter%0d", k), int'(it), m_iter[k]);
        chkm($sformatf("mask%0d", k), mo, m_mask[k]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, busy0, done0, status0, iter0, mout0);
        cmp_inst(1, busy1, done1, status1, iter1, mout1);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [728:0] chain_mask();
        logic [728:0] m;
        m = '0;
        for (int c = 4; c < 81; c++) m[c*9 +: 4] = 4'hF;
        m[8:0]   = 9'h1FE;
        m[17:9]  = 9'h1FC;
        m[26:18] = 9'h1F8;
        m[35:27] = 9'h1F0;
        return m;
    endfunction

    function automatic logic [728:0] chain_final();
        logic [728:0] m;
        m = chain_mask();
        m[17:9]  = 9'h1FD;
        m[26:18] = 9'h1FB;
        m[35:27] = 9'h1F7;
        return m;
    endfunction

    function automatic logic [728:0] gen_puzzle(input int kind);
        logic [728:0] m;
        int perm[9];
        int t, j, v, p, c;
        bit reveal;
        for (int i = 0; i < 9; i++) perm[i] = i;
        for (int i = 8; i > 0; i--) begin
            j = int'($urandom_range(0, i)); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        m = '0;
        p = int'($urandom_range(30, 95));
        for (int cc = 0; cc < 81; cc++) begin
            v = perm[((cc / 9) * 3 + (cc / 9) / 3 + (cc % 9)) % 9];
            reveal = (kind == 2) || (int'($urandom_range(0, 99)) < p);
            for (int d = 0; d < 9; d++)
                if (d != v) m[cc*9+d] = reveal ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
        if (kind == 1) begin
            c = int'($urandom_range(0, 80));
            if ($urandom_range(0, 1) == 0) m[c*9 +: 9] = 9'h1FF;
            else m[c*9 +: 9] = ~(9'h001 << $urandom_range(0, 8));
        end
        if (kind == 3)
            for (int i = 0; i < 729; i++) m[i] = ($urandom_range(0, 1) == 1);
        return m;
    endfunction

    task automatic run_job(input logic [728:0] m, output int lat);
        @(negedge clk);
        mask_in = m; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- directed then random ----------------
    initial begin
        logic [728:0] cm, ce, sg;
        int lat, pulses;
        bit seen;

        cm = chain_mask();
        ce = chain_final();
        sg = '0;
        for (int c = 0; c < 81; c++)
            sg[c*9 +: 9] = ~(9'h001 << (((c / 9) * 3 + (c / 9) / 3 + (c % 9)) % 9));

        chk("pin_prop_moves", int'(prop(cm) != cm), 1);
        chkm("pin_prop_chain3", prop(prop(prop(cm))), ce);
        chkm("pin_prop_fixed", prop(ce), ce);
        chk("pin_solved_grid", int'(all_single(sg)), 1);

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_status", int'(status0), 0);
        chk("rst_iter", int'(iter0), 0);
        chkm("rst_mask", mout0, '0);
        rst_n = 1'b1;

        run_job('0, lat);
        chk("zero_latency", lat, 1);
        chk("zero_status", int'(status0), 3);
        chk("zero_iter", int'(iter0), 0);
        chkm("zero_mask", mout0, '0);
        @(negedge clk);
        chk("zero_done_once", int'(done0), 0);
        chk("zero_idle", int'(busy0), 0);
        chk("zero_held", int'(status0), 3);

        run_job(729'h1FF, lat);
        chk("conflict_latency", lat, 1);
        chk("conflict_status", int'(status0), 2);
        chk("conflict_iter", int'(iter0), 0);

        run_job(sg, lat);
        chk("solved_status", int'(status0), 1);
        chk("solved_iter", int'(iter0), 0);
        chkm("solved_mask", mout0, sg);

        run_job(cm, lat);
        chk("chain_latency", lat, 4);
        chk("chain_status", int'(status0), 3);
        chk("chain_iter", int'(iter0), 3);
        chkm("chain_mask", mout0, ce);
        chk("chain_t1_status", int'(status1), 4);
        chk("chain_t1_iter", int'(iter1), 1);

        @(negedge clk);
        mask_in = cm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_done", int'(done0), 1);
        chk("abort_status", int'(status0), 5);
        chk("abort_iter", int'(iter0), 1);
        pulses = 1;
        repeat (6) begin
            @(negedge clk);
            if (done0) pulses++;
        end
        chk("abort_pulses", pulses, 1);
        chk("abort_held", int'(status0), 5);
        chk("abort_start_ignored", int'(busy0), 0);

        @(negedge clk);
        mask_in = cm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_status", int'(status0), 0);
        chk("midrst_iter", int'(iter0), 0);
        chkm("midrst_mask", mout0, '0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done0;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done0;
        end
        chk("midrst_no_done", int'(seen), 0);
        run_job(cm, lat);
        chk("after_rst_latency", lat, 4);
        chk("after_rst_status", int'(status0), 3);
        chk("after_rst_iter", int'(iter0), 3);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            if (start || $urandom_range(0, 7) == 0)
                mask_in = gen_puzzle(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sudoku_prop_ctrl.md
SUDOKU_PROP_CTRL -- requirements
Module: sudoku_prop_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 64, giving the maximum number of propagation passes per job (legal range 1..255).
REQ-002 The block SHALL have parameter ITER_W, default 8, giving the width of the iteration counter (must hold MAX_ITER).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 abort  input  1  terminates a running job; sampled only in RUN.
REQ-007 mask_in  input  729  initial candidate mask; bit i = x*81+y*9+d, 1 = digit d excluded at cell (x,y).
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse; result fields valid in that cycle and held until the next start.
REQ-010 status  output  3  0 NONE, 1 SOLVED, 2 CONFLICT, 3 STUCK, 4 TIMEOUT, 5 ABORTED.
REQ-011 iter_cnt  output  ITER_W  number of propagation passes applied in the current or last job.
REQ-012 mask_out  output  729  working mask register.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE, with IDLE as the reset state.
REQ-014 In IDLE with start=1, the block SHALL load mask_in into mask_out, clear iter_cnt, set status to NONE and enter RUN.
REQ-015 In IDLE, mask_out, status and iter_cnt SHALL hold their values.
REQ-016 Each RUN cycle SHALL evaluate the current mask_out, with the first matching check taking priority: abort, then conflict (any cell with all 9 bits set), then solved (every cell with exactly 8 bits set), then stuck (propagated mask equals mask_out), then timeout (iter_cnt == MAX_ITER).
REQ-017 When a RUN check matches, the block SHALL write the matching status code, leave mask_out unchanged and enter DONE.
REQ-018 When no RUN check matches, the block SHALL load the propagated mask into mask_out, increment iter_cnt and stay in RUN.
REQ-019 The propagated mask SHALL be the combinational single-pass output of sudoku_mask_stg2 driven by mask_out.
REQ-020 DONE SHALL last exactly one cycle, drive done=1, and go to IDLE.
REQ-021 Minimum latency SHALL be the start sample edge, then the first RUN evaluation edge, with done high in the following cycle (done visible 2 cycles after start is sampled).
REQ-022 Each extra propagation pass SHALL add exactly one cycle of latency.
REQ-023 start SHALL be ignored when busy=1.
REQ-024 abort SHALL be ignored in IDLE and DONE.
REQ-025 When abort and a terminal condition occur in the same cycle, the block SHALL report ABORTED.
REQ-026 iter_cnt SHALL never exceed MAX_ITER and SHALL never wrap.
REQ-027 The conflict and solved checks SHALL be purely combinational, with no extra latency.

Reset
REQ-028 While rst_n=0, the block SHALL be in state IDLE with mask_out = 0, status = NONE, iter_cnt = 0, busy = 0 and done = 0.
REQ-029 Reset asserted mid-job SHALL discard the job immediately and SHALL NOT produce a done pulse.
REQ-030 The first start after reset release SHALL be accepted normally.

Structure
REQ-031 The shared package sudoku_ctrl_pkg SHALL hold the constants NCELL=81, NDIG=9, NBITS=729, the status codes and the FSM state encodings.
REQ-032 The block SHALL contain exactly one sub-module instance, sudoku_mask_stg2, for the single propagation pass.
REQ-033 Per-cell popcount and all-ones detection SHALL be local generate logic inside sudoku_prop_ctrl.

Verification
REQ-034 mask_in = all zeros, start -> STUCK, iter_cnt = 0, done 2 cycles after start, mask_out = 0.
REQ-035 mask_in with bits 0..8 set (cell 0,0 all excluded), start -> CONFLICT, iter_cnt = 0.
REQ-036 Fully solved valid grid (each cell with 8 bits set), start -> SOLVED, iter_cnt = 0, mask_out = mask_in.
REQ-037 A puzzle that needs 3 passes to reach a fixed point: with MAX_ITER=64 -> STUCK/SOLVED at iter_cnt = 3 and done at cycle 5; with MAX_ITER=1 -> TIMEOUT at iter_cnt = 1.
REQ-038 abort asserted in the 2nd RUN cycle -> ABORTED, iter_cnt = 1, single done pulse; a start issued while busy is ignored.
REQ-039 rst_n pulled low in the middle of RUN -> all outputs reset at once, no done pulse; a new start after release completes normally.
